// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, fetches from combinational program memory into an IR with valid flag.
// Optional FETCH_WRAP_HALT_EN: halt after fetching the last memory word instead of wrapping the PC to 0.
module fetch_ctrl #(
  parameter int               Psize   = 4,
  parameter int               Isize   = 17,
  parameter int               OPW     = 4,
  parameter logic [OPW-1:0]   HALT_OP = 4'b1111
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stall,
  input  logic             branch_en,
  input  logic [Psize-1:0] branch_off,
  input  logic             jump_en,
  input  logic [Psize-1:0] jump_addr,
  input  logic [Isize-1:0] I,
  output logic [Psize-1:0] address,
  output logic [Isize-1:0] instr,
  output logic [Psize-1:0] instr_pc,
  output logic             instr_valid,
  output logic             halted
);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t           r_state, w_state_nxt;
  logic [Psize-1:0] r_pc, w_pc_nxt;
  logic [Isize-1:0] r_instr, w_instr_nxt;
  logic [Psize-1:0] r_instr_pc, w_instr_pc_nxt;
  logic             r_valid, w_valid_nxt;
  logic             w_is_halt;

  assign w_is_halt = r_valid && (r_instr[Isize-1 -: OPW] == HALT_OP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_pc       <= '0;
      r_instr    <= '0;
      r_instr_pc <= '0;
      r_valid    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_instr    <= w_instr_nxt;
      r_instr_pc <= w_instr_pc_nxt;
      r_valid    <= w_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_instr_nxt    = r_instr;
    w_instr_pc_nxt = r_instr_pc;
    w_valid_nxt    = r_valid;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = RUN;
          w_pc_nxt    = '0;
        end
      end
      RUN: begin
        if (!stall) begin
          if (w_is_halt) begin
            w_state_nxt = HALT;
            w_valid_nxt = 1'b0;
          end else if (r_valid && jump_en) begin
            w_pc_nxt    = jump_addr;
            w_valid_nxt = 1'b0;
          end else if (r_valid && branch_en) begin
            // Same-width add is the sign-extended offset modulo 2^Psize.
            w_pc_nxt    = r_instr_pc + branch_off;
            w_valid_nxt = 1'b0;
          end else begin
            w_instr_nxt    = I;
            w_instr_pc_nxt = r_pc;
            w_valid_nxt    = 1'b1;
            w_pc_nxt       = r_pc + 1'b1;
`ifdef FETCH_WRAP_HALT_EN
            if (r_pc == '1) w_state_nxt = HALT;
`endif
          end
        end
      end
      HALT: begin
        w_valid_nxt = 1'b0;
        if (start) begin
          w_state_nxt = RUN;
          w_pc_nxt    = '0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign address     = r_pc;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign instr_valid = r_valid;
  assign halted      = (r_state == HALT);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl: vector table for fetch/stall/redirect/wrap,
// hand sequences for async reset, halt opcode and restart.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, stall, branch_en, jump_en;
  logic [3:0]  branch_off, jump_addr;
  logic [16:0] I;
  logic [3:0]  address, instr_pc;
  logic [16:0] instr;
  logic        instr_valid, halted;

  logic [16:0] mem [16];
  int errors = 0;
  int checks = 0;

  fetch_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .branch_en(branch_en), .branch_off(branch_off),
    .jump_en(jump_en), .jump_addr(jump_addr), .I(I),
    .address(address), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .halted(halted)
  );

  assign I = mem[address];
  always #5 clk = ~clk;

  typedef struct {
    logic        st, sl, br, jm;
    logic [3:0]  off, ja;
    logic [3:0]  ea;
    logic [16:0] ei;
    logic [3:0]  ep;
    logic        ev, eh;
  } vec_t;

  vec_t vecs [25];

  function automatic vec_t mk(input logic st, sl, br, input logic [3:0] off, input logic jm,
                              input logic [3:0] ja, ea, input logic [16:0] ei,
                              input logic [3:0] ep, input logic ev, eh);
    vec_t v;
    v.st = st; v.sl = sl; v.br = br; v.off = off; v.jm = jm; v.ja = ja;
    v.ea = ea; v.ei = ei; v.ep = ep; v.ev = ev; v.eh = eh;
    return v;
  endfunction

  task automatic check(input string name, input logic [3:0] ea, input logic [16:0] ei,
                       input logic [3:0] ep, input logic ev, input logic eh);
    checks++;
    if ({address, instr, instr_pc, instr_valid, halted} !== {ea, ei, ep, ev, eh}) begin
      errors++;
      $display("FAIL %s: got addr=%0d instr=%h pc=%0d valid=%b halted=%b, want addr=%0d instr=%h pc=%0d valid=%b halted=%b",
               name, address, instr, instr_pc, instr_valid, halted, ea, ei, ep, ev, eh);
    end
  endtask

  task automatic drive(input logic st, sl, br, input logic [3:0] off, input logic jm,
                       input logic [3:0] ja);
    start = st; stall = sl; branch_en = br; branch_off = off; jump_en = jm; jump_addr = ja;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 17'(i + 1);
    reset = 1'b1;
    start = 0; stall = 0; branch_en = 0; branch_off = 0; jump_en = 0; jump_addr = 0;

    vecs[0]  = mk(1,0,0,0,0,0,   0, 0, 0,0,0);
    vecs[1]  = mk(0,0,0,0,0,0,   1, 1, 0,1,0);
    vecs[2]  = mk(0,0,0,0,0,0,   2, 2, 1,1,0);
    vecs[3]  = mk(0,1,0,0,0,0,   2, 2, 1,1,0);
    vecs[4]  = mk(0,1,0,0,0,0,   2, 2, 1,1,0);
    vecs[5]  = mk(0,1,0,0,0,0,   2, 2, 1,1,0);
    vecs[6]  = mk(0,0,0,0,0,0,   3, 3, 2,1,0);
    vecs[7]  = mk(0,0,0,0,0,0,   4, 4, 3,1,0);
    vecs[8]  = mk(0,0,0,0,0,0,   5, 5, 4,1,0);
    vecs[9]  = mk(0,0,0,0,0,0,   6, 6, 5,1,0);
    vecs[10] = mk(0,0,1,13,0,0,  2, 6, 5,0,0);
    vecs[11] = mk(0,0,1,13,0,0,  3, 3, 2,1,0);
    vecs[12] = mk(0,0,0,0,0,0,   4, 4, 3,1,0);
    vecs[13] = mk(0,0,0,0,0,0,   5, 5, 4,1,0);
    vecs[14] = mk(0,0,0,0,0,0,   6, 6, 5,1,0);
    vecs[15] = mk(0,0,1,13,1,9,  9, 6, 5,0,0);
    vecs[16] = mk(0,0,0,0,0,0,  10,10, 9,1,0);
    vecs[17] = mk(0,1,0,0,1,0,  10,10, 9,1,0);
    vecs[18] = mk(1,0,0,0,0,0,  11,11,10,1,0);
    vecs[19] = mk(0,0,0,0,0,0,  12,12,11,1,0);
    vecs[20] = mk(0,0,0,0,0,0,  13,13,12,1,0);
    vecs[21] = mk(0,0,0,0,0,0,  14,14,13,1,0);
    vecs[22] = mk(0,0,0,0,0,0,  15,15,14,1,0);
`ifdef FETCH_WRAP_HALT_EN
    vecs[23] = mk(0,0,0,0,0,0,   0,16,15,1,1);
    vecs[24] = mk(0,0,0,0,0,0,   0,16,15,0,1);
`else
    vecs[23] = mk(0,0,0,0,0,0,   0,16,15,1,0);
    vecs[24] = mk(0,0,0,0,0,0,   1, 1, 0,1,0);
`endif

    #12;
    check("reset_state", 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 25; i++) begin
      drive(vecs[i].st, vecs[i].sl, vecs[i].br, vecs[i].off, vecs[i].jm, vecs[i].ja);
      check($sformatf("vec%0d", i), vecs[i].ea, vecs[i].ei, vecs[i].ep, vecs[i].ev, vecs[i].eh);
    end

    // Asynchronous reset lands between edges and must clear outputs immediately.
    #2;
    reset = 1'b1;
    #1;
    check("async_reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    drive(0,0,0,0,1,7);
    check("idle_hold", 0, 0, 0, 0, 0);

    mem[3] = 17'h1E000;
    drive(1,0,0,0,0,0); check("h_start",    0, 0,        0,0,0);
    drive(0,0,0,0,0,0); check("h_f0",       1, 1,        0,1,0);
    drive(0,0,0,0,0,0); check("h_f1",       2, 2,        1,1,0);
    drive(0,0,0,0,0,0); check("h_f2",       3, 3,        2,1,0);
    drive(0,0,0,0,0,0); check("h_haltop",   4, 17'h1E000,3,1,0);
    drive(0,0,0,0,1,9); check("h_halted",   4, 17'h1E000,3,0,1);
    drive(0,0,1,13,1,9); check("h_ignore",  4, 17'h1E000,3,0,1);
    drive(1,0,0,0,0,0); check("h_restart",  0, 17'h1E000,3,0,0);
    drive(0,0,0,0,0,0); check("h_refetch",  1, 1,        0,1,0);
    drive(0,0,0,0,0,0); check("h_r1",       2, 2,        1,1,0);
    drive(0,0,0,0,0,0); check("h_r2",       3, 3,        2,1,0);
    drive(0,0,0,0,0,0); check("h_r3",       4, 17'h1E000,3,1,0);
    drive(0,1,0,0,0,0); check("h_stall",    4, 17'h1E000,3,1,0);
    drive(0,0,0,0,0,0); check("h_halt2",    4, 17'h1E000,3,0,1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
